sccb_config: RTL and testbench
==============================

SCCB_CONFIG -- requirements
Module: sccb_config

Interface
REQ-001 Parameter QUARTER, default 63: CLK_25M cycles per SIOC quarter-period (about 99.2 kHz SIOC).
REQ-002 Parameter POWERUP_WAIT, default 25000: cycles waited after START before the first transaction (1 ms).
REQ-003 Parameter GAP, default 250: idle cycles between consecutive transactions.
REQ-004 Parameter DELAY_LONG, default 250000: cycles waited on a delay table entry (10 ms).
REQ-005 Parameter DEV_ID, default 8'h42: SCCB write device address.
REQ-006 CLK_25M  input  1  sole clock, 25 MHz.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 START  input  1  level; sampled in IDLE and DONE; high begins or restarts the configuration sequence.
REQ-009 SIOC  output  1  SCCB clock, driven push-pull.
REQ-010 SIOD_OUT  output  1  SCCB data value.
REQ-011 SIOD_OE  output  1  SCCB data drive enable; pad driven only when 1, else released.
REQ-012 BUSY  output  1  high from sequence start until DONE.
REQ-013 DONE  output  1  high once the end-marker entry is reached; held until restart.
REQ-014 REG_INDEX  output  6  index of the table entry being processed.

Function
REQ-015 FSM states: IDLE, PWR_WAIT, FETCH, START_C, SHIFT, STOP_C, GAP_W, DELAY_W, FIN.
REQ-016 A tick counter of 0..QUARTER-1 shall pulse once per quarter-period; all SCCB phase changes shall occur only on ticks; the counter shall be cleared on every state entry.
REQ-017 IDLE: on START=1, go to PWR_WAIT, set BUSY=1, and set REG_INDEX=0.
REQ-018 PWR_WAIT: after POWERUP_WAIT cycles, go to FETCH.
REQ-019 FETCH: read the 16-bit entry {addr[15:8], data[7:0]} at REG_INDEX; ROM read latency is 1 cycle.
REQ-020 In FETCH, entry 16'hFFFF shall go to FIN; 16'hFFF0 shall go to DELAY_W; any other entry shall go to START_C.
REQ-021 START_C: SIOD_OE=1 with SIOD high and SIOC high; on tick 1 SIOD falls; on tick 2 SIOC falls; then go to SHIFT.
REQ-022 SHIFT: 27 bits are sent as three phases of 8 data bits MSB-first plus 1 don't-care bit: DEV_ID, addr, data.
REQ-023 Each SHIFT bit spans 4 ticks: tick 0 sets SIOD with SIOC low, tick 1 raises SIOC, tick 3 lowers SIOC.
REQ-024 SIOD_OE shall be 0 for the full duration of each 9th (don't-care) bit; the slave response is ignored and no error path exists.
REQ-025 STOP_C: SIOD low and SIOC low; on tick 1 SIOC rises; on tick 2 SIOD rises; on tick 3 SIOD_OE goes to 0; then go to GAP_W.
REQ-026 GAP_W: after GAP cycles, increment REG_INDEX and go to FETCH.
REQ-027 DELAY_W: after DELAY_LONG cycles, increment REG_INDEX and go to FETCH.
REQ-028 REG_INDEX shall wrap from 63 to 0 when incremented; a table without an end marker therefore loops indefinitely, and this is legal.
REQ-029 FIN: DONE=1 and BUSY=0; START=1 shall clear DONE and re-enter PWR_WAIT with REG_INDEX=0.
REQ-030 START is ignored in every state other than IDLE and FIN.

Reset
REQ-031 RST_N low shall asynchronously force state IDLE, SIOC=1, SIOD_OUT=1, SIOD_OE=0, BUSY=0, DONE=0, REG_INDEX=0, and all counters to 0.
REQ-032 Reset asserted mid-transaction shall abort the transaction immediately, with no STOP condition generated; the sequence restarts only on START after release.

Structure
REQ-033 A shared package shall hold the FSM state encoding, END_MARK=16'hFFFF, DELAY_MARK=16'hFFF0, and the table depth constant of 64.
REQ-034 The register table shall be a sub-module ov7670_reg_rom (6-bit address in, 16-bit registered entry out), holding the OV7670 RGB565 VGA init list with entry 0 = 16'h1280 (COM7 reset) and entry 1 = DELAY_MARK.

Verification
REQ-035 Reset, then START=1 with a 3-entry ROM {16'h1280, 16'hFFF0, 16'hFFFF} -> one decoded transaction 42/12/80, a 10 ms gap, then DONE=1 and BUSY=0.
REQ-036 Single entry 16'h40D0 -> bit-accurate waveform: SIOD falls while SIOC is high, 27 SIOC pulses at 4*QUARTER-cycle period, SIOD_OE=0 on bits 9/18/27, and a STOP condition.
REQ-037 Assert RST_N during bit 12 of SHIFT -> outputs take their reset values in the same cycle; no activity until START.
REQ-038 Pulse START during SHIFT -> no effect; sequence completes normally with a single DONE.
REQ-039 ROM with no end marker -> REG_INDEX wraps 63->0 and transactions continue; DONE stays 0.
REQ-040 From FIN, assert START -> DONE clears in 1 cycle and the full sequence reruns from REG_INDEX=0.

Source files
------------

// File: rtl/sccb_config_pkg.sv
// Shared definitions for the SCCB camera configuration engine: FSM encoding,
// table markers and frame geometry.
package sccb_config_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWR_WAIT,
    FETCH,
    START_C,
    SHIFT,
    STOP_C,
    GAP_W,
    DELAY_W,
    FIN
  } state_t;

  localparam logic [15:0] END_MARK    = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK  = 16'hFFF0;
  localparam int          TABLE_DEPTH = 64;
  localparam int          FRAME_BITS  = 27;

  // The 9th bit of each byte is the slave's ack slot; the bus is released there.
  function automatic logic is_ack_slot(input logic [4:0] bit_idx);
    return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table, one {addr, data} word per entry, registered output.
// TABLE_SEL 0 is the RGB565 VGA init list; other values select short bring-up tables.
module ov7670_reg_rom
  import sccb_config_pkg::*;
#(
  parameter int TABLE_SEL = 0
) (
  input  logic        clk,
  input  logic [5:0]  addr,
  output logic [15:0] entry
);

  logic [15:0] rom_word;

  always_comb begin
    rom_word = END_MARK;
    if (TABLE_SEL == 1) begin
      case (addr)
        6'd0:    rom_word = 16'h1280;
        6'd1:    rom_word = DELAY_MARK;
        default: rom_word = END_MARK;
      endcase
    end else if (TABLE_SEL == 2) begin
      case (addr)
        6'd0:    rom_word = 16'h40D0;
        default: rom_word = END_MARK;
      endcase
    end else if (TABLE_SEL == 3) begin
      // Endless table: every slot is a plain write, so the index wraps forever.
      rom_word = {2'b01, addr, 2'b10, addr};
    end else begin
      case (addr)
        6'd0:    rom_word = 16'h1280;
        6'd1:    rom_word = DELAY_MARK;
        6'd2:    rom_word = 16'h1204;
        6'd3:    rom_word = 16'h1101;
        6'd4:    rom_word = 16'h0C00;
        6'd5:    rom_word = 16'h3E00;
        6'd6:    rom_word = 16'h8C00;
        6'd7:    rom_word = 16'h0400;
        6'd8:    rom_word = 16'h40D0;
        6'd9:    rom_word = 16'h3A04;
        6'd10:   rom_word = 16'h1418;
        6'd11:   rom_word = 16'h4FB3;
        6'd12:   rom_word = 16'h50B3;
        6'd13:   rom_word = 16'h5100;
        6'd14:   rom_word = 16'h523D;
        6'd15:   rom_word = 16'h53A7;
        6'd16:   rom_word = 16'h54E4;
        6'd17:   rom_word = 16'h589E;
        6'd18:   rom_word = 16'h3DC0;
        6'd19:   rom_word = 16'h1714;
        6'd20:   rom_word = 16'h1802;
        6'd21:   rom_word = 16'h3280;
        6'd22:   rom_word = 16'h1903;
        6'd23:   rom_word = 16'h1A7B;
        6'd24:   rom_word = 16'h030A;
        6'd25:   rom_word = 16'h0F41;
        6'd26:   rom_word = 16'h1E00;
        6'd27:   rom_word = 16'h330B;
        6'd28:   rom_word = 16'h3C78;
        6'd29:   rom_word = 16'h6900;
        6'd30:   rom_word = 16'h7400;
        6'd31:   rom_word = 16'hB084;
        6'd32:   rom_word = 16'hB10C;
        6'd33:   rom_word = 16'hB20E;
        6'd34:   rom_word = 16'hB380;
        6'd35:   rom_word = 16'h703A;
        6'd36:   rom_word = 16'h7135;
        6'd37:   rom_word = 16'h7211;
        6'd38:   rom_word = 16'h73F0;
        6'd39:   rom_word = 16'hA202;
        6'd40:   rom_word = 16'h13E7;
        6'd41:   rom_word = 16'h6F9F;
        default: rom_word = END_MARK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    entry <= rom_word;
  end

endmodule

// File: rtl/sccb_config.sv
// SCCB master that walks the OV7670 register table once per START, emitting
// three-phase write transactions with power-up, inter-write and delay waits.
module sccb_config
  import sccb_config_pkg::*;
#(
  parameter int         QUARTER      = 63,
  parameter int         POWERUP_WAIT = 25000,
  parameter int         GAP          = 250,
  parameter int         DELAY_LONG   = 250000,
  parameter logic [7:0] DEV_ID       = 8'h42,
  parameter int         TABLE_SEL    = 0
) (
  input  logic       CLK_25M,
  input  logic       RST_N,
  input  logic       START,
  output logic       SIOC,
  output logic       SIOD_OUT,
  output logic       SIOD_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic [5:0] REG_INDEX
);

  localparam int WAIT_MAX = (DELAY_LONG > POWERUP_WAIT)
                          ? ((DELAY_LONG > GAP) ? DELAY_LONG : GAP)
                          : ((POWERUP_WAIT > GAP) ? POWERUP_WAIT : GAP);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int TICK_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [1:0]            qtr;
  logic [4:0]            bit_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [5:0]            reg_index;
  logic [15:0]           entry;
  logic [FRAME_BITS-1:0] frame;
  logic                  tick;
  logic                  fetch_ready;
  logic                  sccb_phase;
  logic                  wait_phase;

  ov7670_reg_rom #(
    .TABLE_SEL(TABLE_SEL)
  ) u_rom (
    .clk  (CLK_25M),
    .addr (reg_index),
    .entry(entry)
  );

  assign tick        = (tick_cnt == TICK_W'(QUARTER - 1));
  // ROM output lags the address by a cycle, so FETCH decodes on its second cycle.
  assign fetch_ready = (wait_cnt != '0);
  assign sccb_phase  = (state == START_C) || (state == SHIFT) || (state == STOP_C);
  assign wait_phase  = (state == PWR_WAIT) || (state == FETCH) ||
                       (state == GAP_W) || (state == DELAY_W);
  assign REG_INDEX   = reg_index;

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (START) state_nxt = PWR_WAIT;
      PWR_WAIT: if (wait_cnt == WAIT_W'(POWERUP_WAIT - 1)) state_nxt = FETCH;
      FETCH: begin
        if (fetch_ready) begin
          if (entry == END_MARK)        state_nxt = FIN;
          else if (entry == DELAY_MARK) state_nxt = DELAY_W;
          else                          state_nxt = START_C;
        end
      end
      START_C:  if (tick && qtr == 2'd2) state_nxt = SHIFT;
      SHIFT:    if (tick && qtr == 2'd3 && bit_cnt == 5'(FRAME_BITS - 1)) state_nxt = STOP_C;
      STOP_C:   if (tick && qtr == 2'd3) state_nxt = GAP_W;
      GAP_W:    if (wait_cnt == WAIT_W'(GAP - 1)) state_nxt = FETCH;
      DELAY_W:  if (wait_cnt == WAIT_W'(DELAY_LONG - 1)) state_nxt = FETCH;
      FIN:      if (START) state_nxt = PWR_WAIT;
      default:  state_nxt = IDLE;
    endcase
  end

  // Every counter restarts on a state change, so phases are counted from entry.
  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      tick_cnt <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (wait_phase) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (sccb_phase) begin
        if (tick) begin
          tick_cnt <= '0;
          qtr      <= qtr + 2'd1;
          if (qtr == 2'd3) bit_cnt <= bit_cnt + 5'd1;
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      reg_index <= '0;
    end else if ((state == IDLE || state == FIN) && START) begin
      reg_index <= '0;
    end else if ((state == GAP_W || state == DELAY_W) && state_nxt == FETCH) begin
      reg_index <= reg_index + 6'd1;
    end
  end

  always_ff @(posedge CLK_25M) begin
    if (state == FETCH && fetch_ready) begin
      frame <= {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    end else if (state == SHIFT && tick && qtr == 2'd3) begin
      frame <= {frame[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_comb begin
    SIOC     = 1'b1;
    SIOD_OUT = 1'b1;
    SIOD_OE  = 1'b0;
    BUSY     = (state != IDLE) && (state != FIN);
    DONE     = (state == FIN);
    case (state)
      START_C: begin
        SIOD_OE  = 1'b1;
        SIOD_OUT = (qtr == 2'd0);
        SIOC     = (qtr != 2'd2);
      end
      SHIFT: begin
        SIOD_OE  = !is_ack_slot(bit_cnt);
        SIOD_OUT = frame[FRAME_BITS-1];
        SIOC     = (qtr == 2'd1) || (qtr == 2'd2);
      end
      STOP_C: begin
        SIOD_OE  = (qtr != 2'd3);
        SIOD_OUT = (qtr >= 2'd2);
        SIOC     = (qtr != 2'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_config.sv
// Directed bench for sccb_config: cycle timeline of a short table, decoded
// SCCB frames, restart/ignore behaviour, index wrap and asynchronous reset.
module tb_sccb_config;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] sioc, siod, oe, busy, done;
  logic [5:0] idx_a, idx_b, idx_c;

  int checks = 0;
  int errors = 0;

  sccb_config #(.QUARTER(4), .POWERUP_WAIT(20), .GAP(10), .DELAY_LONG(100),
                .DEV_ID(8'h42), .TABLE_SEL(1)) dut_a (
    .CLK_25M(clk), .RST_N(rst_n), .START(start[0]), .SIOC(sioc[0]),
    .SIOD_OUT(siod[0]), .SIOD_OE(oe[0]), .BUSY(busy[0]), .DONE(done[0]),
    .REG_INDEX(idx_a));

  sccb_config #(.QUARTER(4), .POWERUP_WAIT(20), .GAP(10), .DELAY_LONG(100),
                .DEV_ID(8'h42), .TABLE_SEL(2)) dut_b (
    .CLK_25M(clk), .RST_N(rst_n), .START(start[1]), .SIOC(sioc[1]),
    .SIOD_OUT(siod[1]), .SIOD_OE(oe[1]), .BUSY(busy[1]), .DONE(done[1]),
    .REG_INDEX(idx_b));

  sccb_config #(.QUARTER(2), .POWERUP_WAIT(20), .GAP(10), .DELAY_LONG(100),
                .DEV_ID(8'h42), .TABLE_SEL(3)) dut_c (
    .CLK_25M(clk), .RST_N(rst_n), .START(start[2]), .SIOC(sioc[2]),
    .SIOD_OUT(siod[2]), .SIOD_OE(oe[2]), .BUSY(busy[2]), .DONE(done[2]),
    .REG_INDEX(idx_c));

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    int         cyc;
    logic       busy;
    logic       done;
    logic       sioc;
    logic       siod;
    logic       siod_c;
    logic       oe;
    logic [5:0] idx;
  } step_t;

  step_t tl[$];

  logic [26:0] cap_d   [3];
  logic [26:0] cap_oe  [3];
  int          cap_min [3];
  int          cap_max [3];
  bit          cap_st  [3];
  bit          cap_sp  [3];

  function automatic logic [5:0] idx_of(input int s);
    case (s)
      0:       return idx_a;
      1:       return idx_b;
      default: return idx_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic capture(input int s, input int budget,
                         output logic [26:0] d, output logic [26:0] oe_bits,
                         output int pmin, output int pmax, output bit st, output bit sp);
    int   n;
    int   last;
    logic ps, pd;
    n = 0; last = 0; d = '0; oe_bits = '0;
    pmin = 32'h7fffffff; pmax = 0; st = 0; sp = 0;
    ps = sioc[s]; pd = siod[s];
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!st) begin
        if (ps && sioc[s] && pd && !siod[s] && oe[s]) st = 1;
      end else if (n < 27) begin
        if (!ps && sioc[s]) begin
          d[26-n]       = siod[s];
          oe_bits[26-n] = oe[s];
          if (n > 0) begin
            if (c - last < pmin) pmin = c - last;
            if (c - last > pmax) pmax = c - last;
          end
          last = c;
          n++;
        end
      end else if (ps && sioc[s] && !pd && siod[s]) begin
        sp = 1;
        break;
      end
      ps = sioc[s]; pd = siod[s];
    end
  endtask

  task automatic check_txn(input int s, input string tag, input logic [7:0] ea,
                           input logic [7:0] ed, input int per);
    check({tag, "_start_cond"}, 32'(cap_st[s]), 32'd1);
    check({tag, "_stop_cond"},  32'(cap_sp[s]), 32'd1);
    check({tag, "_dev"},        32'(cap_d[s][26:19]), 32'h42);
    check({tag, "_addr"},       32'(cap_d[s][17:10]), 32'(ea));
    check({tag, "_data"},       32'(cap_d[s][8:1]),   32'(ed));
    check({tag, "_oe_pattern"}, 32'(cap_oe[s]), 32'(27'b111111110_111111110_111111110));
    check({tag, "_period_min"}, 32'(cap_min[s]), 32'(per));
    check({tag, "_period_max"}, 32'(cap_max[s]), 32'(per));
  endtask

  task automatic run_timeline();
    int cur;
    cur = 0;
    foreach (tl[i]) begin
      while (cur < tl[i].cyc) begin
        @(posedge clk);
        cur++;
      end
      @(negedge clk);
      check({tl[i].name, "_busy"}, 32'(busy[0]), 32'(tl[i].busy));
      check({tl[i].name, "_done"}, 32'(done[0]), 32'(tl[i].done));
      check({tl[i].name, "_sioc"}, 32'(sioc[0]), 32'(tl[i].sioc));
      if (tl[i].siod_c) check({tl[i].name, "_siod"}, 32'(siod[0]), 32'(tl[i].siod));
      check({tl[i].name, "_oe"},   32'(oe[0]),   32'(tl[i].oe));
      check({tl[i].name, "_idx"},  32'(idx_a),   32'(tl[i].idx));
    end
  endtask

  initial begin
    int  done_rises;
    bit  seen_done;
    bit  activity;
    logic pdone;

    // Timeline of table {1280, FFF0, FFFF}, cycles counted from the START edge.
    tl.push_back('{"pwr_entry",   0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"pwr_last",   19, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"fetch0",     21, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"start_q0",   22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"start_q1",   26, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"start_q2",   30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit0_q0",    34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit0_q1",    38, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit0_q3",    46, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit1_q1",    54, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"ack1_q1",   166, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0});
    tl.push_back('{"bit12_q1",  230, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit18_q1",  326, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"bit19_q1",  342, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"ack3_q1",   454, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0});
    tl.push_back('{"stop_q0",   466, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"stop_q1",   470, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"stop_q2",   474, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0});
    tl.push_back('{"stop_q3",   478, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"gap_entry", 482, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"gap_last",  491, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
    tl.push_back('{"fetch1",    492, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1});
    tl.push_back('{"delay_ent", 494, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1});
    tl.push_back('{"delay_last",593, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1});
    tl.push_back('{"fetch2",    594, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2});
    tl.push_back('{"fetch2_b",  595, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2});
    tl.push_back('{"fin",       596, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2});

    rst_n = 1'b0;
    start = 3'b000;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d_sioc", s), 32'(sioc[s]), 32'd1);
      check($sformatf("rst%0d_siod", s), 32'(siod[s]), 32'd1);
      check($sformatf("rst%0d_oe", s),   32'(oe[s]),   32'd0);
      check($sformatf("rst%0d_busy", s), 32'(busy[s]), 32'd0);
      check($sformatf("rst%0d_done", s), 32'(done[s]), 32'd0);
      check($sformatf("rst%0d_idx", s),  32'(idx_of(s)), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int s = 0; s < 3; s++) check($sformatf("idle%0d_busy", s), 32'(busy[s]), 32'd0);

    // Short table on A and single 40D0 write on B, started together.
    start = 3'b011;
    @(posedge clk);
    #1 start = 3'b000;
    fork
      run_timeline();
      capture(0, 800, cap_d[0], cap_oe[0], cap_min[0], cap_max[0], cap_st[0], cap_sp[0]);
      capture(1, 800, cap_d[1], cap_oe[1], cap_min[1], cap_max[1], cap_st[1], cap_sp[1]);
    join
    check_txn(0, "a_txn", 8'h12, 8'h80, 16);
    check_txn(1, "b_txn", 8'h40, 8'hD0, 16);
    check("b_done", 32'(done[1]), 32'd1);
    check("b_busy", 32'(busy[1]), 32'd0);
    check("b_idx",  32'(idx_b),   32'd1);

    // Restart B from FIN; a START pulse mid-SHIFT must be ignored.
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    @(negedge clk);
    check("restart_done_clr", 32'(done[1]), 32'd0);
    check("restart_busy",     32'(busy[1]), 32'd1);
    check("restart_idx",      32'(idx_b),   32'd0);
    fork
      capture(1, 800, cap_d[1], cap_oe[1], cap_min[1], cap_max[1], cap_st[1], cap_sp[1]);
      begin
        repeat (133) @(posedge clk);
        #1;
        check("pulse_in_shift_busy", 32'(busy[1]), 32'd1);
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
      end
    join
    check_txn(1, "b_rerun", 8'h40, 8'hD0, 16);
    done_rises = 0;
    pdone = done[1];
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done[1] && !pdone) done_rises++;
      pdone = done[1];
    end
    check("b_single_done", 32'(done_rises), 32'd1);
    check("b_rerun_done",  32'(done[1]),    32'd1);
    check("b_rerun_busy",  32'(busy[1]),    32'd0);

    // Endless table on C: index must wrap 63 -> 0 without DONE.
    seen_done = 0;
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    #1 start[2] = 1'b0;
    for (int c = 0; c < 20000 && idx_c != 6'd63; c++) begin
      @(negedge clk);
      if (done[2]) seen_done = 1;
    end
    check("c_reach63", 32'(idx_c), 32'd63);
    for (int c = 0; c < 600 && idx_c == 6'd63; c++) begin
      @(negedge clk);
      if (done[2]) seen_done = 1;
    end
    check("c_wrap0",     32'(idx_c),     32'd0);
    check("c_busy",      32'(busy[2]),   32'd1);
    check("c_no_done",   32'(seen_done), 32'd0);
    capture(2, 800, cap_d[2], cap_oe[2], cap_min[2], cap_max[2], cap_st[2], cap_sp[2]);
    check_txn(2, "c_after_wrap", 8'h40, 8'h80, 8);

    // Reset B during bit 12 of SHIFT (second quarter, SIOC high).
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    repeat (232) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy[1]), 32'd1);
    check("pre_rst_sioc", 32'(sioc[1]), 32'd1);
    check("pre_rst_oe",   32'(oe[1]),   32'd1);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("midrst%0d_sioc", s), 32'(sioc[s]), 32'd1);
      check($sformatf("midrst%0d_siod", s), 32'(siod[s]), 32'd1);
      check($sformatf("midrst%0d_oe", s),   32'(oe[s]),   32'd0);
      check($sformatf("midrst%0d_busy", s), 32'(busy[s]), 32'd0);
      check($sformatf("midrst%0d_done", s), 32'(done[s]), 32'd0);
      check($sformatf("midrst%0d_idx", s),  32'(idx_of(s)), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    activity = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy != 3'b000 || sioc != 3'b111 || oe != 3'b000 || done != 3'b000) activity = 1;
    end
    check("post_rst_quiet", 32'(activity), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
